// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator: pixel/line counters with visible-area, sync and
// data-enable decode, plus a percentage register that only changes at frame wrap.
module lcd_timing_gen #(
    parameter int col_max_pantalla  = 800,
    parameter int fila_max_pantalla = 480,
    parameter int h_fp              = 210,
    parameter int h_sync            = 20,
    parameter int h_bp              = 26,
    parameter int v_fp              = 22,
    parameter int v_sync            = 10,
    parameter int v_bp              = 13,
    localparam int n_col            = $clog2(col_max_pantalla),
    localparam int n_fil            = $clog2(fila_max_pantalla)
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             ena,
    input  logic [6:0]       porcentaje_in,
    output logic [n_col-1:0] columna,
    output logic [n_fil-1:0] fila,
    output logic             HD,
    output logic             VD,
    output logic             DEN,
    output logic             frame_start,
    output logic [6:0]       porcentaje
);

    localparam int H_TOTAL = col_max_pantalla + h_fp + h_sync + h_bp;
    localparam int V_TOTAL = fila_max_pantalla + v_fp + v_sync + v_bp;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS      = HW'(col_max_pantalla);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(col_max_pantalla + h_fp);
    localparam logic [HW-1:0] H_SYNC_END = HW'(col_max_pantalla + h_fp + h_sync);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS      = VW'(fila_max_pantalla);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(fila_max_pantalla + v_fp);
    localparam logic [VW-1:0] V_SYNC_END = VW'(fila_max_pantalla + v_fp + v_sync);

    localparam logic [6:0] PCT_MAX = 7'd100;

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [6:0]    pct_q, pct_d;
    logic          h_wrap, v_wrap, frame_wrap;

    function automatic logic [6:0] sat_pct(input logic [6:0] p);
        return (p > PCT_MAX) ? PCT_MAX : p;
    endfunction

    assign h_wrap     = (h_cnt_q == H_LAST);
    assign v_wrap     = (v_cnt_q == V_LAST);
    assign frame_wrap = ena && h_wrap && v_wrap;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (ena) begin
            if (h_wrap) begin
                h_cnt_d = '0;
                v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Percentage is latched only on the edge that closes the frame, so the bar never tears.
    always_comb begin
        pct_d = pct_q;
        if (frame_wrap) begin
            pct_d = sat_pct(porcentaje_in);
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            pct_q   <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            pct_q   <= pct_d;
        end
    end

    // Zero-latency decode straight off the counter registers.
    always_comb begin
        DEN         = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        HD          = !((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
        VD          = !((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));
        columna     = (h_cnt_q < H_VIS) ? h_cnt_q[n_col-1:0] : '0;
        fila        = (v_cnt_q < V_VIS) ? v_cnt_q[n_fil-1:0] : '0;
        frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
        porcentaje  = pct_q;
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen on a shrunken 24x15 raster: table vectors, a per-cycle
// scoreboard fed from a reference model, and hand sequences for frame/ena/reset cases.
module tb_lcd_timing_gen;

    localparam int COL = 16, FIL = 8;
    localparam int HFP = 3, HSY = 2, HBP = 3;
    localparam int VFP = 2, VSY = 2, VBP = 3;
    localparam int HT = COL + HFP + HSY + HBP;  // 24
    localparam int VT = FIL + VFP + VSY + VBP;  // 15

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       ena = 1'b0;
    logic [6:0] porcentaje_in = '0;
    logic [3:0] columna;
    logic [2:0] fila;
    logic       HD, VD, DEN, frame_start;
    logic [6:0] porcentaje;

    lcd_timing_gen #(
        .col_max_pantalla(COL), .fila_max_pantalla(FIL),
        .h_fp(HFP), .h_sync(HSY), .h_bp(HBP),
        .v_fp(VFP), .v_sync(VSY), .v_bp(VBP)
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .ena(ena), .porcentaje_in(porcentaje_in),
        .columna(columna), .fila(fila), .HD(HD), .VD(VD), .DEN(DEN),
        .frame_start(frame_start), .porcentaje(porcentaje)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    int m_h = 0, m_v = 0;
    logic [6:0] m_pct = '0;
    logic [17:0] sb_q[$];
    int cnt_vd, cnt_hd, cnt_den, cnt_fs;

    function automatic logic [17:0] mk(int c, int f, bit hd, bit vd, bit den, bit fs, int p);
        return {4'(c), 3'(f), hd, vd, den, fs, 7'(p)};
    endfunction

    function automatic logic [17:0] model_outs(int h, int v, logic [6:0] p);
        bit hv = (h < COL), vv = (v < FIL);
        return mk(hv ? h : 0, vv ? v : 0,
                  !(h >= 19 && h <= 20), !(v >= 10 && v <= 11),
                  hv && vv, (h == 0) && (v == 0), p);
    endfunction

    function automatic logic [17:0] dut_outs();
        return {columna, fila, HD, VD, DEN, frame_start, porcentaje};
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic [6:0] pin);
        logic [17:0] exp;
        ena = e;
        porcentaje_in = pin;
        if (e) begin
            if (m_h == HT - 1) begin
                m_h = 0;
                if (m_v == VT - 1) begin
                    m_v = 0;
                    m_pct = (pin > 7'd100) ? 7'd100 : pin;
                end else begin
                    m_v++;
                end
            end else begin
                m_h++;
            end
        end
        sb_q.push_back(model_outs(m_h, m_v, m_pct));
        @(posedge CLK);
        #1;
        exp = sb_q.pop_front();
        check("scoreboard", dut_outs(), exp);
        if (!VD) cnt_vd++;
        if (!HD) cnt_hd++;
        if (DEN) cnt_den++;
        if (frame_start) cnt_fs++;
    endtask

    typedef struct {
        string      name;
        int         n;
        logic [6:0] pin;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[14];

    initial begin
        //                    col fil HD VD DEN FS pct
        vecs[0]  = '{"reset",      0,   7'd0,   mk(0,  0, 1, 1, 1, 1, 0)};
        vecs[1]  = '{"col15",      15,  7'd37,  mk(15, 0, 1, 1, 1, 0, 0)};
        vecs[2]  = '{"h16_blank",  1,   7'd37,  mk(0,  0, 1, 1, 0, 0, 0)};
        vecs[3]  = '{"hd_first",   3,   7'd37,  mk(0,  0, 0, 1, 0, 0, 0)};
        vecs[4]  = '{"hd_last",    1,   7'd37,  mk(0,  0, 0, 1, 0, 0, 0)};
        vecs[5]  = '{"hd_end",     1,   7'd37,  mk(0,  0, 1, 1, 0, 0, 0)};
        vecs[6]  = '{"line1",      3,   7'd37,  mk(0,  1, 1, 1, 1, 0, 0)};
        vecs[7]  = '{"vd_first",   216, 7'd37,  mk(0,  0, 1, 0, 0, 0, 0)};
        vecs[8]  = '{"vd_end",     48,  7'd37,  mk(0,  0, 1, 1, 0, 0, 0)};
        vecs[9]  = '{"wrap_64",    72,  7'd64,  mk(0,  0, 1, 1, 1, 1, 64)};
        vecs[10] = '{"sat_120",    360, 7'd120, mk(0,  0, 1, 1, 1, 1, 100)};
        vecs[11] = '{"zero_pct",   360, 7'd0,   mk(0,  0, 1, 1, 1, 1, 0)};
        vecs[12] = '{"pct_100",    360, 7'd100, mk(0,  0, 1, 1, 1, 1, 100)};
        vecs[13] = '{"midframe",   5,   7'd101, mk(5,  0, 1, 1, 1, 0, 100)};

        #23;
        check("in_reset", dut_outs(), mk(0, 0, 1, 1, 1, 1, 0));
        RST_n = 1'b1;
        #1;

        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < vecs[i].n; k++) step(1'b1, vecs[i].pin);
            check(vecs[i].name, dut_outs(), vecs[i].exp);
        end

        // Finish the frame (h=5 -> wrap), 101 at the wrap edge saturates to 100.
        for (int k = 0; k < 355; k++) step(1'b1, 7'd101);
        check("wrap_101", dut_outs(), mk(0, 0, 1, 1, 1, 1, 100));

        // One full enabled frame: count decoded output activity.
        cnt_vd = 0; cnt_hd = 0; cnt_den = 0; cnt_fs = 0;
        for (int k = 0; k < HT * VT; k++) step(1'b1, 7'd50);
        check_int("vd_low_cycles", cnt_vd, 2 * HT);
        check_int("hd_low_cycles", cnt_hd, 2 * VT);
        check_int("den_cycles", cnt_den, COL * FIL);
        check_int("fs_per_frame", cnt_fs, 1);
        check("frame_pct", dut_outs(), mk(0, 0, 1, 1, 1, 1, 50));

        // Alternating enable: frame takes twice the cycles, outputs hold on ena=0.
        cnt_fs = 0;
        for (int k = 0; k < 2 * HT * VT; k++) step((k % 2) == 0, 7'd20);
        check_int("fs_toggle", cnt_fs, 2);
        check("toggle_end", dut_outs(), mk(0, 0, 1, 1, 1, 1, 20));

        // Park at h=10, v=5 then pulse reset between clock edges.
        for (int k = 0; k < 5 * HT + 10; k++) step(1'b1, 7'd20);
        check("pre_reset", dut_outs(), mk(10, 5, 1, 1, 1, 0, 20));
        #2;
        RST_n = 1'b0;
        #1;
        check("async_reset", dut_outs(), mk(0, 0, 1, 1, 1, 1, 0));
        #1;
        RST_n = 1'b1;
        m_h = 0; m_v = 0; m_pct = '0;
        step(1'b1, 7'd20);
        check("post_reset", dut_outs(), mk(1, 0, 1, 1, 1, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
